// File: rtl/vending_machine_core.sv
// Sequential vending core: balance register, inactivity timer and greedy change return.
// Sits between the coin/selection front-end and the dispenser/coin-hopper drivers.
module vending_machine_core #(
    parameter int                         K_NUM_COINS = 3,
    parameter int                         K_NUM_ITEMS = 4,
    parameter int                         TOTAL_BITS  = 31,
    parameter int                         WAIT_CYCLES = 100,
    parameter logic [K_NUM_COINS*32-1:0]  COIN_VALUES = {32'd1000, 32'd500, 32'd100},
    parameter logic [K_NUM_ITEMS*32-1:0]  ITEM_PRICES = {32'd2000, 32'd1000, 32'd500, 32'd400}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [K_NUM_COINS-1:0]  i_input_coin,
    input  logic [K_NUM_ITEMS-1:0]  i_select_item,
    input  logic                    i_trigger_return,
    output logic [K_NUM_ITEMS-1:0]  o_available_item,
    output logic [K_NUM_ITEMS-1:0]  o_output_item,
    output logic [K_NUM_COINS-1:0]  o_return_coin,
    output logic                    o_coin_reject,
    output logic [TOTAL_BITS-1:0]   o_current_total,
    output logic                    o_busy
);

    // Wide enough that neither the multi-coin sum nor a 32-bit price can wrap.
    localparam int SUM_BITS  = ((TOTAL_BITS > 32) ? TOTAL_BITS : 32) + $clog2(K_NUM_COINS + 1) + 1;
    localparam int WAIT_BITS = $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_RETURN = 2'd2;

    localparam logic [SUM_BITS-1:0]  TOTAL_MAX = {{(SUM_BITS-TOTAL_BITS){1'b0}}, {TOTAL_BITS{1'b1}}};
    localparam logic [WAIT_BITS-1:0] WAIT_LOAD = WAIT_BITS'(WAIT_CYCLES);
    localparam logic [WAIT_BITS-1:0] WAIT_ONE  = WAIT_BITS'(1);

    logic [1:0]             r_state;
    logic [TOTAL_BITS-1:0]  r_total;
    logic [WAIT_BITS-1:0]   r_wait_cnt;
    logic [K_NUM_ITEMS-1:0] r_output_item;
    logic [K_NUM_COINS-1:0] r_return_coin;
    logic                   r_coin_reject;

    logic [1:0]             w_state_next;
    logic [TOTAL_BITS-1:0]  w_total_next;
    logic [WAIT_BITS-1:0]   w_wait_next;
    logic [K_NUM_ITEMS-1:0] w_item_next;
    logic [K_NUM_COINS-1:0] w_ret_next;
    logic                   w_reject_next;

    logic [SUM_BITS-1:0]    w_total_ext;
    logic [SUM_BITS-1:0]    w_coin_term [K_NUM_COINS];
    logic [SUM_BITS-1:0]    w_coin_value [K_NUM_COINS];
    logic [SUM_BITS-1:0]    w_item_price [K_NUM_ITEMS];
    logic [K_NUM_COINS-1:0] w_coin_fits;
    logic [K_NUM_ITEMS-1:0] w_affordable;
    logic [SUM_BITS-1:0]    w_coin_sum;
    logic                   w_in_return;
    logic                   w_accept;

    logic                   w_disp_valid;
    logic [K_NUM_ITEMS-1:0] w_disp_onehot;
    logic [SUM_BITS-1:0]    w_disp_price;
    logic                   w_dispense;

    logic                   w_ret_valid;
    logic [K_NUM_COINS-1:0] w_ret_onehot;
    logic [SUM_BITS-1:0]    w_ret_value;

    assign w_total_ext = SUM_BITS'(r_total);
    assign w_in_return = (r_state == S_RETURN);

    genvar gi;
    generate
        for (gi = 0; gi < K_NUM_COINS; gi++) begin : g_coin
            assign w_coin_value[gi] = SUM_BITS'(COIN_VALUES[32*gi +: 32]);
            assign w_coin_term[gi]  = i_input_coin[gi] ? w_coin_value[gi] : '0;
            assign w_coin_fits[gi]  = (w_coin_value[gi] <= w_total_ext);
        end
        for (gi = 0; gi < K_NUM_ITEMS; gi++) begin : g_item
            assign w_item_price[gi] = SUM_BITS'(ITEM_PRICES[32*gi +: 32]);
            assign w_affordable[gi] = (w_total_ext >= w_item_price[gi]);
        end
    endgenerate

    always_comb begin
        w_coin_sum = '0;
        for (int j = 0; j < K_NUM_COINS; j++) begin
            w_coin_sum = w_coin_sum + w_coin_term[j];
        end
    end

    // All-or-nothing: any overflow refuses every coin presented this cycle.
    assign w_accept = (|i_input_coin) && !w_in_return && ((w_total_ext + w_coin_sum) <= TOTAL_MAX);

    // Descending scan so the lowest affordable selected index wins.
    always_comb begin
        w_disp_valid  = 1'b0;
        w_disp_onehot = '0;
        w_disp_price  = '0;
        for (int i = K_NUM_ITEMS - 1; i >= 0; i--) begin
            if (i_select_item[i] && w_affordable[i]) begin
                w_disp_valid  = 1'b1;
                w_disp_onehot = '0;
                w_disp_onehot[i] = 1'b1;
                w_disp_price  = w_item_price[i];
            end
        end
    end

    assign w_dispense = w_disp_valid && !i_trigger_return && !w_in_return;

    // Ascending scan so the largest coin that still fits wins (greedy change).
    always_comb begin
        w_ret_valid  = 1'b0;
        w_ret_onehot = '0;
        w_ret_value  = '0;
        for (int j = 0; j < K_NUM_COINS; j++) begin
            if (w_coin_fits[j]) begin
                w_ret_valid  = 1'b1;
                w_ret_onehot = '0;
                w_ret_onehot[j] = 1'b1;
                w_ret_value  = w_coin_value[j];
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_total_next  = r_total;
        w_wait_next   = r_wait_cnt;
        w_item_next   = '0;
        w_ret_next    = '0;
        w_reject_next = (|i_input_coin) && !w_accept;
        case (r_state)
            S_RETURN: begin
                if (w_ret_valid) begin
                    w_ret_next   = w_ret_onehot;
                    w_total_next = TOTAL_BITS'(w_total_ext - w_ret_value);
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                // Any non-ACTIVE encoding here behaves as IDLE and recovers to it.
                if (r_state != S_ACTIVE) begin
                    w_state_next = S_IDLE;
                end
                w_total_next = TOTAL_BITS'(w_total_ext
                                           + (w_accept   ? w_coin_sum   : '0)
                                           - (w_dispense ? w_disp_price : '0));
                if (w_dispense) begin
                    w_item_next = w_disp_onehot;
                end
                if (i_trigger_return && ((r_state == S_ACTIVE) || w_coin_fits[0])) begin
                    w_state_next = S_RETURN;
                end else if (w_accept || w_dispense) begin
                    w_state_next = S_ACTIVE;
                    w_wait_next  = WAIT_LOAD;
                end else if (r_state == S_ACTIVE) begin
                    if (r_wait_cnt == WAIT_ONE) begin
                        w_state_next = S_RETURN;
                    end else begin
                        w_wait_next = r_wait_cnt - WAIT_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_total       <= '0;
            r_wait_cnt    <= '0;
            r_output_item <= '0;
            r_return_coin <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_total       <= w_total_next;
            r_wait_cnt    <= w_wait_next;
            r_output_item <= w_item_next;
            r_return_coin <= w_ret_next;
            r_coin_reject <= w_reject_next;
        end
    end

    assign o_available_item = w_affordable & {K_NUM_ITEMS{!w_in_return}};
    assign o_output_item    = r_output_item;
    assign o_return_coin    = r_return_coin;
    assign o_coin_reject    = r_coin_reject;
    assign o_current_total  = r_total;
    assign o_busy           = w_in_return;

endmodule
